mem_arbiter: RTL and testbench

Shares one single-port data memory between NREQ pipelined cores. Each core keeps its own MemWrite/ALUOut/WriteData/ReadData style port. The arbiter serialises their accesses with round-robin fairness and returns a one-cycle completion pulse that the core's hazard unit uses as its memory-stall release. It sits between the cores' memory-stage outputs and the shared RAM, which has a fixed read latency.

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  mem_arb_pkg : shared types and round-robin pick helper for mem_arbiter
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam int c_MAX_REQ = 8;

   // Requests are zero-extended to 8 bits; the empty upper bits make a
   // mod-8 scan visit requesters in the same order as a mod-NREQ scan.
   function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
      logic [2:0] idx;
      logic       found;
      rr_pick = last;
      found   = 1'b0;
      for (int i = 1; i <= c_MAX_REQ; i++) begin
         idx = last + 3'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  rr_arbiter : combinational round-robin selector (search from last+1, wrap)
//  Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int GW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [GW-1:0]   i_last,
   output logic [GW-1:0]   o_gnt,
   output logic            o_valid
);

   logic [7:0] w_req8;

   always_comb begin
      w_req8            = '0;
      w_req8[NREQ-1:0]  = i_req;
   end

   assign o_gnt   = GW'(rr_pick(w_req8, 3'(i_last)));
   assign o_valid = |i_req;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  mem_arbiter : round-robin sharing of one fixed-latency RAM between NREQ
//                cores. Optional perf counters under macro ARB_PERF_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_i,
   input  logic [NREQ-1:0]   we_i,
   input  logic [NREQ*AW-1:0] addr_i,
   input  logic [NREQ*DW-1:0] wdata_i,
   output logic [NREQ-1:0]   done_o,
   output logic [DW-1:0]     rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [AW-1:0]     mem_addr_o,
   output logic [DW-1:0]     mem_wdata_o,
   input  logic [DW-1:0]     mem_rdata_i
`ifdef ARB_PERF_EN
   ,
   output logic [NREQ*32-1:0] grant_cnt_o,
   output logic [NREQ*32-1:0] wait_cnt_o
`endif
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(MEM_LAT + 1);

   arb_state_t      r_state;
   logic [GW-1:0]   r_g;
   logic [GW-1:0]   r_last;
   logic            r_we;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic [CW-1:0]   r_cnt;
   logic [NREQ-1:0] r_done;
   logic [DW-1:0]   r_rdata;

   logic [GW-1:0]   w_gnt;
   logic            w_valid;
   logic            w_issue;

   rr_arbiter #(
      .NREQ (NREQ),
      .GW   (GW)
   ) u_rr (
      .i_req   (req_i),
      .i_last  (r_last),
      .o_gnt   (w_gnt),
      .o_valid (w_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_g     <= '0;
         r_last  <= GW'(NREQ - 1);
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
         r_done  <= '0;
         r_rdata <= '0;
      end else begin
         r_done <= '0;
         case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_g     <= w_gnt;
                  r_we    <= we_i[w_gnt];
                  r_addr  <= addr_i[w_gnt*AW +: AW];
                  r_wdata <= wdata_i[w_gnt*DW +: DW];
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (r_we) begin
                  r_done[r_g] <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_cnt   <= CW'(MEM_LAT);
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               // count==1 marks the cycle the RAM presents the read data
               if (r_cnt == CW'(1)) begin
                  r_rdata     <= mem_rdata_i;
                  r_done[r_g] <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            DONE: begin
               r_last  <= r_g;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_issue     = (r_state == ISSUE);
   assign mem_en_o    = w_issue;
   assign mem_we_o    = w_issue & r_we;
   assign mem_addr_o  = w_issue ? r_addr  : '0;
   assign mem_wdata_o = w_issue ? r_wdata : '0;
   assign done_o      = r_done;
   assign rdata_o     = r_rdata;

`ifdef ARB_PERF_EN
   for (genvar r = 0; r < NREQ; r++) begin : g_perf
      logic [31:0] r_gcnt;
      logic [31:0] r_wcnt;
      logic        w_serving;

      assign w_serving = (r_state != IDLE) && (r_g == GW'(r));

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_gcnt <= '0;
            r_wcnt <= '0;
         end else begin
            if ((r_state == DONE) && (r_g == GW'(r)) && (r_gcnt != '1)) begin
               r_gcnt <= r_gcnt + 32'd1;
            end
            if (req_i[r] && !w_serving && (r_wcnt != '1)) begin
               r_wcnt <= r_wcnt + 32'd1;
            end
         end
      end

      assign grant_cnt_o[r*32 +: 32] = r_gcnt;
      assign wait_cnt_o[r*32 +: 32]  = r_wcnt;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  tb_mem_arbiter : bench for mem_arbiter at MEM_LAT 2/1/4 with a RAM model,
//                   a transaction-level reference and directed vectors.
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

   localparam int NREQ = 2;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int NI   = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   errors = 0;

   logic            s_req   [NI][NREQ];
   logic            s_we    [NI][NREQ];
   logic [AW-1:0]   s_addr  [NI][NREQ];
   logic [DW-1:0]   s_wdata [NI][NREQ];

   logic [NREQ-1:0]    p_req   [NI];
   logic [NREQ-1:0]    p_we    [NI];
   logic [NREQ*AW-1:0] p_addr  [NI];
   logic [NREQ*DW-1:0] p_wdata [NI];

   logic [NREQ-1:0] done      [NI];
   logic [DW-1:0]   rdata     [NI];
   logic            mem_en    [NI];
   logic            mem_we    [NI];
   logic [AW-1:0]   mem_addr  [NI];
   logic [DW-1:0]   mem_wdata [NI];
   logic [DW-1:0]   mem_rdata [NI];
`ifdef ARB_PERF_EN
   logic [NREQ*32-1:0] gcnt_o [NI];
   logic [NREQ*32-1:0] wcnt_o [NI];
`endif

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : (i == 1) ? 1 : 4;
   endfunction

   always_comb begin
      for (int i = 0; i < NI; i++) begin
         p_req[i]   = '0;
         p_we[i]    = '0;
         p_addr[i]  = '0;
         p_wdata[i] = '0;
         for (int r = 0; r < NREQ; r++) begin
            p_req[i][r]              = s_req[i][r];
            p_we[i][r]               = s_we[i][r];
            p_addr[i][r*AW +: AW]    = s_addr[i][r];
            p_wdata[i][r*DW +: DW]   = s_wdata[i][r];
         end
      end
   end

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int L = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
      logic [DW-1:0] ram  [256];
      logic [DW-1:0] pipe [4];

      mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MEM_LAT(L)) u_dut (
         .clk         (clk),
         .reset       (reset),
         .req_i       (p_req[gi]),
         .we_i        (p_we[gi]),
         .addr_i      (p_addr[gi]),
         .wdata_i     (p_wdata[gi]),
         .done_o      (done[gi]),
         .rdata_o     (rdata[gi]),
         .mem_en_o    (mem_en[gi]),
         .mem_we_o    (mem_we[gi]),
         .mem_addr_o  (mem_addr[gi]),
         .mem_wdata_o (mem_wdata[gi]),
         .mem_rdata_i (mem_rdata[gi])
`ifdef ARB_PERF_EN
         ,
         .grant_cnt_o (gcnt_o[gi]),
         .wait_cnt_o  (wcnt_o[gi])
`endif
      );

      // RAM: read data appears exactly L cycles after the strobe, poison otherwise
      always @(posedge clk) begin
         if (mem_en[gi] && mem_we[gi]) ram[mem_addr[gi][7:0]] <= mem_wdata[gi];
         pipe[0] <= (mem_en[gi] && !mem_we[gi]) ? ram[mem_addr[gi][7:0]] : 32'hBAD0_0000;
         for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
      end
      assign mem_rdata[gi] = pipe[L-1];
   end

   // ---------------- transaction-level reference ----------------
   logic          m_busy [NI];
   int            m_t    [NI];
   int            m_len  [NI];
   int            m_g    [NI];
   int            m_last [NI];
   logic          m_we   [NI];
   logic [AW-1:0] m_addr [NI];
   logic [DW-1:0] m_wdata[NI];
   logic [DW-1:0] m_rd   [NI];
   logic [DW-1:0] mmem   [NI][256];
`ifdef ARB_PERF_EN
   logic [31:0]   m_gc   [NI][NREQ];
   logic [31:0]   m_wc   [NI][NREQ];
`endif

   function automatic int pick(input int i);
      int w;
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
         if (w < 0 && s_req[i][(m_last[i] + k) % NREQ]) w = (m_last[i] + k) % NREQ;
      end
      return w;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NI; i++) begin
            m_busy[i] <= 1'b0;
            m_t[i]    <= 0;
            m_len[i]  <= 0;
            m_g[i]    <= 0;
            m_last[i] <= NREQ - 1;
`ifdef ARB_PERF_EN
            for (int r = 0; r < NREQ; r++) begin
               m_gc[i][r] <= '0;
               m_wc[i][r] <= '0;
            end
`endif
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
`ifdef ARB_PERF_EN
            for (int r = 0; r < NREQ; r++) begin
               if (s_req[i][r] && !(m_busy[i] && m_g[i] == r)) m_wc[i][r] <= m_wc[i][r] + 1;
            end
`endif
            if (!m_busy[i]) begin
               if (pick(i) >= 0) begin
                  m_busy[i]  <= 1'b1;
                  m_t[i]     <= 1;
                  m_g[i]     <= pick(i);
                  m_we[i]    <= s_we[i][pick(i)];
                  m_addr[i]  <= s_addr[i][pick(i)];
                  m_wdata[i] <= s_wdata[i][pick(i)];
                  m_len[i]   <= s_we[i][pick(i)] ? 2 : 2 + lat_of(i);
                  if (s_we[i][pick(i)]) mmem[i][s_addr[i][pick(i)][7:0]] <= s_wdata[i][pick(i)];
                  else                  m_rd[i] <= mmem[i][s_addr[i][pick(i)][7:0]];
               end
            end else if (m_t[i] == m_len[i]) begin
               m_busy[i] <= 1'b0;
               m_t[i]    <= 0;
               m_last[i] <= m_g[i];
`ifdef ARB_PERF_EN
               m_gc[i][m_g[i]] <= m_gc[i][m_g[i]] + 1;
`endif
            end else begin
               m_t[i] <= m_t[i] + 1;
            end
         end
      end
   end

   task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, inst, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < NI; i++) begin
            chk("done", i, 64'(done[i]),
                (m_busy[i] && m_t[i] == m_len[i]) ? (64'd1 << m_g[i]) : 64'd0);
            chk("mem_en", i, 64'(mem_en[i]), 64'(m_busy[i] && m_t[i] == 1));
            chk("mem_we", i, 64'(mem_we[i]), 64'(m_busy[i] && m_t[i] == 1 && m_we[i]));
            if (m_busy[i] && m_t[i] == 1) begin
               chk("mem_addr", i, 64'(mem_addr[i]), 64'(m_addr[i]));
               if (m_we[i]) chk("mem_wdata", i, 64'(mem_wdata[i]), 64'(m_wdata[i]));
            end
            if (m_busy[i] && m_t[i] == m_len[i] && !m_we[i])
               chk("rdata", i, 64'(rdata[i]), 64'(m_rd[i]));
`ifdef ARB_PERF_EN
            for (int r = 0; r < NREQ; r++) begin
               chk("grant_cnt", i, 64'(gcnt_o[i][r*32 +: 32]), 64'(m_gc[i][r]));
               chk("wait_cnt", i, 64'(wcnt_o[i][r*32 +: 32]), 64'(m_wc[i][r]));
            end
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic access(input int i, input int r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd);
      int   c0;
      logic got;
      @(negedge clk);
      s_we[i][r]    = w;
      s_addr[i][r]  = a;
      s_wdata[i][r] = d;
      s_req[i][r]   = 1'b1;
      c0  = cyc;
      got = 1'b0;
      lat = -1;
      rd  = '0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (done[i][r]) begin
            got = 1'b1;
            lat = cyc - c0;
            rd  = rdata[i];
         end
      end
      s_req[i][r] = 1'b0;
      chk("done_seen", i, 64'(got), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic chk_zero(input int i);
      chk("rst_done", i, 64'(done[i]), 64'd0);
      chk("rst_rdata", i, 64'(rdata[i]), 64'd0);
      chk("rst_mem_en", i, 64'(mem_en[i]), 64'd0);
      chk("rst_mem_we", i, 64'(mem_we[i]), 64'd0);
      chk("rst_mem_addr", i, 64'(mem_addr[i]), 64'd0);
      chk("rst_mem_wdata", i, 64'(mem_wdata[i]), 64'd0);
   endtask

   int          lat, l0, l1, n_got, first;
   logic [31:0] rd, d0, d1;
   logic        seen;
   int          order [4];
   int          exp_order [4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_order = '{0, 1, 0, 1};
      for (int i = 0; i < NI; i++)
         for (int r = 0; r < NREQ; r++) begin
            s_req[i][r] = 1'b0; s_we[i][r] = 1'b0; s_addr[i][r] = '0; s_wdata[i][r] = '0;
         end

      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) chk_zero(i);
      #2 reset = 1'b1;

      // single write then read-back, MEM_LAT=2
      access(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd);
      chk("wr_latency", 0, 64'(lat), 64'd2);
      access(0, 1, 1'b0, 32'h10, 32'h0, lat, rd);
      chk("rd_latency", 0, 64'(lat), 64'd4);
      chk("rd_data", 0, 64'(rd), 64'hDEADBEEF);
      access(0, 1, 1'b1, 32'h20, 32'h12345678, lat, rd);

      // MEM_LAT=1 and MEM_LAT=4 reads
      access(1, 0, 1'b1, 32'h40, 32'hCAFEF00D, lat, rd);
      access(1, 1, 1'b0, 32'h40, 32'h0, lat, rd);
      chk("rd_latency_l1", 1, 64'(lat), 64'd3);
      chk("rd_data_l1", 1, 64'(rd), 64'hCAFEF00D);
      access(2, 0, 1'b1, 32'h44, 32'h0BADCAFE, lat, rd);
      access(2, 1, 1'b0, 32'h44, 32'h0, lat, rd);
      chk("rd_latency_l4", 2, 64'(lat), 64'd6);
      chk("rd_data_l4", 2, 64'(rd), 64'h0BADCAFE);

      // contention: both held high, grants must alternate
      do_reset();
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) begin
         s_we[0][r] = 1'b1; s_addr[0][r] = 32'h30 + 32'(4*r);
         s_wdata[0][r] = 32'hA000_0000 + 32'(r); s_req[0][r] = 1'b1;
      end
      n_got = 0;
      for (int n = 0; n < 60 && n_got < 4; n++) begin
         @(negedge clk);
         if (done[0] != '0) begin
            order[n_got] = done[0][1] ? 1 : 0;
            n_got++;
         end
      end
      s_req[0][0] = 1'b0;
      s_req[0][1] = 1'b0;
      chk("rr_count", 0, 64'(n_got), 64'd4);
      for (int k = 0; k < 4; k++) chk("rr_order", 0, 64'(order[k]), 64'(exp_order[k]));

      // reset during WAIT
      @(negedge clk);
      s_we[0][1] = 1'b0; s_addr[0][1] = 32'h20; s_req[0][1] = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         if (mem_en[0]) seen = 1'b1;
      end
      chk("issue_seen", 0, 64'(seen), 64'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1 chk_zero(0);
      s_req[0][1] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("done_in_reset", 0, 64'(done[0]), 64'd0);
      end
      s_we[0][0] = 1'b0; s_addr[0][0] = 32'h10; s_req[0][0] = 1'b1;
      s_we[0][1] = 1'b0; s_addr[0][1] = 32'h20; s_req[0][1] = 1'b1;
      #2 reset = 1'b1;
      first = 0;
      for (int n = 0; n < 20 && first == 0; n++) begin
         @(negedge clk);
         if (done[0] != '0) first = int'(done[0]);
      end
      chk("first_grant", 0, 64'(first), 64'd1);
      s_req[0][0] = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (done[0][1]) seen = 1'b1;
      end
      s_req[0][1] = 1'b0;
      chk("second_grant", 0, 64'(seen), 64'd1);

      // three contended reads from reset
      do_reset();
      fork
         begin : f_r0
            access(0, 0, 1'b0, 32'h10, 32'h0, l0, d0);
            access(0, 0, 1'b0, 32'h20, 32'h0, l0, d0);
         end
         begin : f_r1
            access(0, 1, 1'b0, 32'h10, 32'h0, l1, d1);
         end
      join
      @(negedge clk);
      chk("perf_rd0", 0, 64'(d0), 64'h12345678);
      chk("perf_rd1", 0, 64'(d1), 64'hDEADBEEF);
`ifdef ARB_PERF_EN
      chk("grant_sum", 0, 64'(gcnt_o[0][31:0]) + 64'(gcnt_o[0][63:32]), 64'd3);
      chk("wait_r1", 0, 64'(wcnt_o[0][63:32]), 64'd6);
      chk("wait_r0", 0, 64'(wcnt_o[0][31:0]), 64'd7);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
